pe_mac_sequencer: RTL and testbench

Sequences one `pe` processing element through a dot-product job of programmable length. It accepts a job command, streams weight/activation pairs into the PE, and tracks PE pipeline latency. It accumulates the PE products into a 24-bit result, which it returns over a valid/ready handshake. It sits between the job/operand streams and a single `pe` instance.

---
 rtl/pe_seq_pkg.sv | 17 +
 rtl/pe.sv | 36 +++
 rtl/pe_lat_tracker.sv | 25 ++
 rtl/pe_mac_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_pkg.sv
// Shared widths, FSM state encoding and accumulator type for the pe MAC sequencer.
package pe_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef logic [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/pe.sv
// Processing element: o_sum = i_sum + i_weight * i_activation, delayed by LATENCY registered stages.
module pe #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_weight,
    input  logic [DATA_W-1:0] i_activation,
    input  logic [ACC_W-1:0]  i_sum,
    output logic [ACC_W-1:0]  o_sum
);
    logic [2*DATA_W-1:0] prod_s;
    logic [ACC_W-1:0]    mac_s;
    logic [ACC_W-1:0]    pipe_r [LATENCY];

    assign prod_s = {{DATA_W{1'b0}}, i_weight} * {{DATA_W{1'b0}}, i_activation};
    assign mac_s  = i_sum + {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
    assign o_sum  = pipe_r[LATENCY-1];

    // MAC result pipeline
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_r[i] <= {ACC_W{1'b0}};
            end
        end else begin
            pipe_r[0] <= mac_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

endmodule

// File: rtl/pe_lat_tracker.sv
// Valid-bit shift register mirroring the pe pipeline so each product is recognised exactly once.
module pe_lat_tracker #(
    parameter int LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    output logic tail,
    output logic empty
);
    logic [LATENCY-1:0] sr_r;

    assign tail  = sr_r[LATENCY-1];
    assign empty = (sr_r == {LATENCY{1'b0}});

    // Shift in one valid bit per cycle; the oldest bit leaves at the tail
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_r <= {LATENCY{1'b0}};
        end else begin
            sr_r <= LATENCY'({sr_r, push});
        end
    end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Drives one pe through a biased dot-product job and returns the accumulated sum.
// Build option: define PE_SEQ_SAT_EN for saturating accumulation with a sticky overflow flag.
module pe_mac_sequencer
    import pe_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int PE_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ACC_W-1:0]  cmd_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] in_activation,
    output logic [DATA_W-1:0] pe_weight,
    output logic [DATA_W-1:0] pe_activation,
    output logic [ACC_W-1:0]  pe_sum,
    input  logic [ACC_W-1:0]  pe_o_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic              res_overflow
);
    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    seq_state_t        state_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W:0]    issued_r;
    logic [LEN_W:0]    added_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_next_s;
    logic [ACC_W-1:0]  res_sum_r;
    logic [DATA_W-1:0] pe_weight_r;
    logic [DATA_W-1:0] pe_activation_r;
    logic              pe_valid_r;
    logic              cmd_ready_r;
    logic              in_ready_r;
    logic              res_valid_r;
    logic              accept_s;
    logic              issue_s;
    logic              tail_s;
    logic              empty_s;
    logic              drained_s;
    logic [LEN_W:0]    len_ext_s;
    logic [LEN_W:0]    issued_inc_s;

    assign cmd_ready     = cmd_ready_r;
    assign in_ready      = in_ready_r;
    assign res_valid     = res_valid_r;
    assign res_sum       = res_sum_r;
    assign pe_weight     = pe_weight_r;
    assign pe_activation = pe_activation_r;
    assign pe_sum        = {ACC_W{1'b0}};

    assign accept_s     = (state_r == IDLE) && cmd_ready_r && cmd_valid;
    assign issue_s      = (state_r == RUN) && in_ready_r && in_valid;
    assign len_ext_s    = {1'b0, len_r};
    assign issued_inc_s = issued_r + CNT_ONE;
    // pe_valid_r is the stage in front of the tracker, so it must be clear as well
    assign drained_s    = empty_s && !pe_valid_r && (added_r == len_ext_s);

    // The tracker is fed in step with the registered pe operands, so its tail lines up with pe_o_sum
    pe_lat_tracker #(
        .LATENCY (PE_LATENCY)
    ) u_lat (
        .clock (clock),
        .reset (reset),
        .push  (pe_valid_r),
        .tail  (tail_s),
        .empty (empty_s)
    );

`ifdef PE_SEQ_SAT_EN
    logic [ACC_W:0] sum_wide_s;
    logic           ovf_set_s;
    logic           ovf_r;

    assign res_overflow = ovf_r;

    // Saturating accumulate: a carry-out pins the accumulator at all-ones
    always_comb begin
        sum_wide_s = {1'b0, acc_r} + {1'b0, pe_o_sum};
        acc_next_s = acc_r;
        ovf_set_s  = 1'b0;
        if (tail_s) begin
            if (sum_wide_s[ACC_W]) begin
                acc_next_s = {ACC_W{1'b1}};
                ovf_set_s  = 1'b1;
            end else begin
                acc_next_s = sum_wide_s[ACC_W-1:0];
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Overflow flag is sticky within a job and cleared when the next job is accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`else
    assign res_overflow = 1'b0;

    // Wrapping accumulate of each product that reaches the tracker tail
    always_comb begin
        if (tail_s) begin
            acc_next_s = acc_r + pe_o_sum;
        end else begin
            acc_next_s = acc_r;
        end
    end
`endif

    // Job FSM with its registered handshake outputs, operand staging and counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            len_r           <= {LEN_W{1'b0}};
            issued_r        <= {(LEN_W+1){1'b0}};
            added_r         <= {(LEN_W+1){1'b0}};
            acc_r           <= {ACC_W{1'b0}};
            res_sum_r       <= {ACC_W{1'b0}};
            pe_weight_r     <= {DATA_W{1'b0}};
            pe_activation_r <= {DATA_W{1'b0}};
            pe_valid_r      <= 1'b0;
            cmd_ready_r     <= 1'b0;
            in_ready_r      <= 1'b0;
            res_valid_r     <= 1'b0;
        end else begin
            acc_r           <= acc_next_s;
            pe_weight_r     <= issue_s ? in_weight : {DATA_W{1'b0}};
            pe_activation_r <= issue_s ? in_activation : {DATA_W{1'b0}};
            pe_valid_r      <= issue_s;
            if (tail_s) begin
                added_r <= added_r + CNT_ONE;
            end else begin
                added_r <= added_r;
            end

            case (state_r)
                IDLE: begin
                    in_ready_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                    if (accept_s) begin
                        len_r       <= cmd_len;
                        acc_r       <= cmd_bias;
                        issued_r    <= {(LEN_W+1){1'b0}};
                        added_r     <= {(LEN_W+1){1'b0}};
                        cmd_ready_r <= 1'b0;
                        if (cmd_len == {LEN_W{1'b0}}) begin
                            state_r     <= DONE;
                            res_valid_r <= 1'b1;
                            res_sum_r   <= cmd_bias;
                        end else begin
                            state_r    <= RUN;
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    cmd_ready_r <= 1'b0;
                    res_valid_r <= 1'b0;
                    if (issue_s) begin
                        issued_r <= issued_inc_s;
                        if (issued_inc_s >= len_ext_s) begin
                            in_ready_r <= 1'b0;
                            state_r    <= DRAIN;
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        in_ready_r <= in_ready_r;
                    end
                end
                DRAIN: begin
                    cmd_ready_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    if (drained_s) begin
                        state_r     <= DONE;
                        res_valid_r <= 1'b1;
                        res_sum_r   <= acc_r;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    in_ready_r <= 1'b0;
                    if (res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        cmd_ready_r <= 1'b0;
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench: pe_mac_sequencer wired to a real pe, expected sums computed by hand.
module tb_pe_mac_sequencer;
    import pe_seq_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ACC_W;
    localparam int LW = DEF_LEN_W;
    localparam int PL = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] cmd_bias = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_weight = '0;
    logic [DW-1:0] in_activation = '0;
    logic [DW-1:0] pe_weight;
    logic [DW-1:0] pe_activation;
    logic [AW-1:0] pe_sum;
    logic [AW-1:0] pe_o_sum;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_sum;
    logic          res_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] vw   [0:7];
    logic [DW-1:0] va   [0:7];
    logic          vpat [0:15];

    always #5 clock = ~clock;

    pe_mac_sequencer #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .PE_LATENCY(PL)) u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight), .in_activation(in_activation),
        .pe_weight(pe_weight), .pe_activation(pe_activation), .pe_sum(pe_sum), .pe_o_sum(pe_o_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_overflow(res_overflow)
    );

    pe #(.DATA_W(DW), .ACC_W(AW), .LATENCY(PL)) u_pe (
        .clock(clock), .reset(reset),
        .i_weight(pe_weight), .i_activation(pe_activation), .i_sum(pe_sum), .o_sum(pe_o_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a command until the handshake edge has passed
    task automatic start_cmd(input logic [LW-1:0] len, input logic [AW-1:0] bias);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_bias  = bias;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // mode 0: always valid from tables, 1: vpat gating, 2: constant (1,1)
    task automatic feed(input int n_pairs, input int mode, output int cycles);
        int   idx = 0;
        int   c = 0;
        logic rdy;
        while (idx < n_pairs && c < 600) begin
            in_valid = (mode == 1) ? vpat[c % 16] : 1'b1;
            if (mode == 2) begin
                in_weight     = 8'd1;
                in_activation = 8'd1;
            end else begin
                in_weight     = vw[idx % 8];
                in_activation = va[idx % 8];
            end
            rdy = in_ready;
            tick();
            c++;
            if (in_valid && rdy) idx++;
        end
        in_valid      = 1'b0;
        in_weight     = '0;
        in_activation = '0;
        cycles = c;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 400) begin
            tick();
            n++;
        end
    endtask

    // Check result, then consume it and confirm return to IDLE
    task automatic take_res(input string tag, input logic [AW-1:0] exp_sum, input logic exp_ovf);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
        chk({tag, "_ovf"}, 32'(res_overflow), 32'(exp_ovf));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_fall"}, 32'(res_valid), 32'd0);
        chk({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int   fc;
        int   wc;
        acc_t exp_sum;
        logic [AW-1:0] held;

        for (int i = 0; i < 16; i++) vpat[i] = 1'b1;

        // Reset values
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        chk("rst_res_ovf", 32'(res_overflow), 32'd0);
        chk("rst_pe_weight", 32'(pe_weight), 32'd0);
        chk("rst_pe_act", 32'(pe_activation), 32'd0);
        chk("rst_pe_sum", 32'(pe_sum), 32'd0);
        #3 reset = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic job with latency check
        vw[0] = 8'd1; va[0] = 8'd2;
        vw[1] = 8'd3; va[1] = 8'd4;
        vw[2] = 8'd5; va[2] = 8'd0;
        vw[3] = 8'd2; va[3] = 8'd2;
        exp_sum = 24'h000010 + 24'd2 + 24'd12 + 24'd0 + 24'd4;
        start_cmd(8'd4, 24'h000010);
        feed(4, 0, fc);
        wait_res(wc);
        chk("basic_latency", 32'(fc + wc), 32'(4 + PL + 2));
        chk("basic_sum_pre", 32'(res_sum), 32'(exp_sum));

        // Backpressure while the result waits
        held = res_sum;
        cmd_valid = 1'b1; cmd_len = 8'd3; cmd_bias = 24'h000111;
        in_valid = 1'b1; in_weight = 8'h55; in_activation = 8'h66;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res_sum", 32'(res_sum), 32'(held));
        end
        cmd_valid = 1'b0; in_valid = 1'b0; in_weight = '0; in_activation = '0;
        take_res("basic", exp_sum, 1'b0);

        // Bubbles on the operand stream
        vw[0] = 8'hFF; va[0] = 8'hFF;
        vw[1] = 8'h10; va[1] = 8'h10;
        vw[2] = 8'h01; va[2] = 8'h01;
        vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0;
        vpat[3] = 1'b1; vpat[4] = 1'b0; vpat[5] = 1'b1;
        exp_sum = 24'h000100 + 24'h00FE01 + 24'h000100 + 24'h000001;
        start_cmd(8'd3, 24'h000100);
        feed(3, 1, fc);
        chk("bubble_feed_cycles", 32'(fc), 32'd6);
        wait_res(wc);
        take_res("bubble", exp_sum, 1'b0);

        // Zero-length job
        start_cmd(8'd0, 24'hABCDEF);
        wait_res(wc);
        chk("zl_within_2", 32'(wc <= 2), 32'd1);
        chk("zl_pe_weight", 32'(pe_weight), 32'd0);
        chk("zl_pe_act", 32'(pe_activation), 32'd0);
        take_res("zero_len", 24'hABCDEF, 1'b0);

        // Accumulator overflow
        vw[0] = 8'h10; va[0] = 8'h10;
        start_cmd(8'd1, 24'hFFFF00);
        feed(1, 0, fc);
        wait_res(wc);
`ifdef PE_SEQ_SAT_EN
        take_res("overflow", 24'hFFFFFF, 1'b1);
`else
        take_res("overflow", 24'h000000, 1'b0);
`endif

        // Maximum length: counter must not wrap; overflow flag cleared by the new accept
        start_cmd(8'd255, 24'h000000);
        feed(255, 2, fc);
        wait_res(wc);
        chk("max_latency", 32'(fc + wc), 32'(255 + PL + 2));
        take_res("max_len", 24'd255, 1'b0);

        // Reset in the middle of a job, then a fresh job
        vw[0] = 8'd9; va[0] = 8'd9;
        vw[1] = 8'd7; va[1] = 8'd2;
        start_cmd(8'd4, 24'h000033);
        feed(2, 0, fc);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_sum", 32'(res_sum), 32'd0);
        chk("mid_rst_pe_weight", 32'(pe_weight), 32'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        vw[0] = 8'd3; va[0] = 8'd7;
        start_cmd(8'd1, 24'h000005);
        feed(1, 0, fc);
        wait_res(wc);
        take_res("after_rst", 24'h000005 + 24'd21, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
